// File: rtl/xmr_probe_capture.sv
// Change-driven capture of three probed nets into a first-word-fall-through FIFO.
// Each record is {timestamp, other, O, I}, taken when the sampled vector changes or right after (re)arming.
module xmr_probe_capture #(
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      ASYNCRESETN,
  input  logic                      en,
  input  logic                      clear,
  input  logic                      I,
  input  logic                      O,
  input  logic                      other,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TS_WIDTH+2:0]       out_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [7:0]                drop_count
);

  localparam int AW     = $clog2(DEPTH);
  localparam int DATA_W = TS_WIDTH + 3;

  localparam logic [TS_WIDTH-1:0] TS_ONE   = 1;
  localparam logic [AW-1:0]       PTR_ONE  = 1;
  localparam logic [AW:0]         CNT_ONE  = 1;
  localparam logic [AW:0]         CNT_FULL = (AW+1)'(DEPTH);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [TS_WIDTH-1:0] ts_p0;
  logic [2:0]          prev_p0;
  logic                armed_p0;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [DATA_W-1:0]   last_data;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [2:0] s;
  logic       ev;
  logic       pop;
  logic       full;
  logic       push;
  logic       drop_ev;

  always_comb begin
    s       = {other, O, I};
    ev      = en & (armed_p0 | (s != prev_p0));
    pop     = out_valid & out_ready;
    full    = (count == CNT_FULL);
    push    = ev & (~full | pop) & ~clear;
    drop_ev = ev & full & ~pop & ~clear;
  end

  // Head is driven from registered state only; when empty the last shown head is held.
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : last_data;

  // Storage carries no reset: only entries between rd_ptr and wr_ptr are ever shown.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {ts_p0, s};
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      ts_p0      <= '0;
      prev_p0    <= '0;
      armed_p0   <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      last_data  <= '0;
    end else begin
      ts_p0     <= ts_p0 + TS_ONE;
      armed_p0  <= clear | ~en;
      last_data <= out_data;
      if (en) begin
        prev_p0 <= s;
      end
      if (clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        overflow   <= 1'b0;
        drop_count <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        if (push && !pop) begin
          count <= count + CNT_ONE;
        end else if (pop && !push) begin
          count <= count - CNT_ONE;
        end
        if (drop_ev) begin
          overflow   <= 1'b1;
          drop_count <= sat_inc8(drop_count);
        end
      end
    end
  end

endmodule

// File: tb/tb_xmr_probe_capture.sv
// Bench for xmr_probe_capture: directed scenarios plus random traffic checked against a queue model.
module tb_xmr_probe_capture;
  localparam int DEPTH = 8;
  localparam int TSW   = 16;
  localparam int DW    = TSW + 3;

  logic          CLK = 1'b0;
  logic          ASYNCRESETN;
  logic          en, clear, I, O, other, out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [3:0]    count;
  logic          overflow;
  logic [7:0]    drop_count;

  xmr_probe_capture #(.DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .en(en), .clear(clear),
    .I(I), .O(O), .other(other),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  int unsigned   ts_m;
  logic [2:0]    prev_m;
  bit            armed_m;
  logic [DW-1:0] q[$];
  bit            ovf_m;
  int            drop_m;
  logic [DW-1:0] data_m;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ts_m    = 0;
    prev_m  = 3'b000;
    armed_m = 1'b1;
    q.delete();
    ovf_m   = 1'b0;
    drop_m  = 0;
    data_m  = '0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".out_valid"},  32'(out_valid),  32'(q.size() > 0));
    chk({ph, ".count"},      32'(count),      32'(q.size()));
    chk({ph, ".out_data"},   32'(out_data),   32'(data_m));
    chk({ph, ".overflow"},   32'(overflow),   32'(ovf_m));
    chk({ph, ".drop_count"}, 32'(drop_count), 32'(drop_m));
  endtask

  // One clock edge: advance the model from the current inputs, then compare after the edge.
  task automatic step(input string ph);
    logic [2:0] s;
    bit ev, pop;
    s   = {other, O, I};
    ev  = en && (armed_m || (s != prev_m));
    pop = (q.size() > 0) && out_ready;
    if (clear) begin
      q.delete();
      ovf_m  = 1'b0;
      drop_m = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (ev) begin
        if (q.size() < DEPTH) q.push_back({ts_m[TSW-1:0], s});
        else begin
          ovf_m = 1'b1;
          if (drop_m < 255) drop_m++;
        end
      end
    end
    armed_m = clear || !en;
    if (en) prev_m = s;
    ts_m = (ts_m + 1) % (1 << TSW);
    if (q.size() > 0) data_m = q[0];
    @(posedge CLK);
    #1;
    check_all(ph);
  endtask

  task automatic drain();
    en = 1'b0; clear = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) step("drain");
    chk("drain.empty", 32'(count), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    ASYNCRESETN = 1'b0;
    en = 1'b0; clear = 1'b0; I = 1'b0; O = 1'b0; other = 1'b0; out_ready = 1'b0;
    model_reset();
    #12;
    chk("rst.out_valid",  32'(out_valid),  32'd0);
    chk("rst.out_data",   32'(out_data),   32'd0);
    chk("rst.count",      32'(count),      32'd0);
    chk("rst.overflow",   32'(overflow),   32'd0);
    chk("rst.drop_count", 32'(drop_count), 32'd0);
    #8 ASYNCRESETN = 1'b1;

    // Baseline at edge 0, I toggles at edge 3
    en = 1'b1;
    step("bl.e0");
    chk("bl.valid_e0", 32'(out_valid), 32'd1);
    step("bl.e1");
    step("bl.e2");
    I = 1'b1;
    step("bl.e3");
    chk("bl.count", 32'(count), 32'd2);
    chk("bl.head0", 32'(out_data), 32'h0);
    out_ready = 1'b1;
    step("bl.pop0");
    chk("bl.head1", 32'(out_data), 32'h19);
    drain();

    // Constant input for 21 enabled cycles: only the baseline is recorded
    en = 1'b1;
    for (int k = 0; k < 21; k++) step("nochg");
    chk("nochg.count", 32'(count), 32'd1);
    drain();

    // Toggle other for 12 cycles with the reader stalled
    en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      other = ~other;
      step("ovf");
    end
    chk("ovf.count", 32'(count), 32'd8);
    chk("ovf.flag",  32'(overflow), 32'd1);
    chk("ovf.drops", 32'(drop_count), 32'd4);

    // Push and pop in the same cycle while full
    out_ready = 1'b1;
    other = ~other;
    step("fullpp");
    chk("fullpp.count", 32'(count), 32'd8);
    chk("fullpp.drops", 32'(drop_count), 32'd4);
    out_ready = 1'b0;
    step("fullpp.hold");

    // Clear together with an event and a pop
    clear = 1'b1; out_ready = 1'b1;
    other = ~other;
    step("clr");
    chk("clr.count", 32'(count), 32'd0);
    chk("clr.valid", 32'(out_valid), 32'd0);
    chk("clr.ovf",   32'(overflow), 32'd0);
    chk("clr.drops", 32'(drop_count), 32'd0);
    clear = 1'b0; out_ready = 1'b0;
    step("clr.base");
    chk("clr.base_count", 32'(count), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      clear     = ($urandom_range(0, 49) == 0);
      out_ready = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 2) == 0) {other, O, I} = 3'($urandom);
      step("rnd");
    end
    drain();

    // Async reset with five entries held
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      I = ~I;
      step("ar.fill");
    end
    chk("ar.count5", 32'(count), 32'd5);
    #2 ASYNCRESETN = 1'b0;
    #1;
    model_reset();
    chk("ar.out_valid",  32'(out_valid),  32'd0);
    chk("ar.out_data",   32'(out_data),   32'd0);
    chk("ar.count",      32'(count),      32'd0);
    chk("ar.overflow",   32'(overflow),   32'd0);
    chk("ar.drop_count", 32'(drop_count), 32'd0);
    #1 ASYNCRESETN = 1'b1;
    step("ar.first");
    chk("ar.first_valid", 32'(out_valid), 32'd1);
    chk("ar.first_ts",    32'(out_data[DW-1:3]), 32'd0);
    step("ar.next");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/xmr_probe_capture.md
# xmr_probe_capture

Change-driven capture buffer for signals probed out of a design by a bound monitor. It samples the three probed nets (`I`, `O`, `other`) and records each change of value together with a cycle timestamp. Records are written into an internal FIFO and drained by a downstream reader over a valid/ready stream. It writes the sample stream that a bound terminating monitor only observes, and it is instantiated through `bind` next to that monitor in verification builds.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `TS_WIDTH`, 16: timestamp counter width.

- `CLK`  in  1  clock, all state on rising edge.
- `ASYNCRESETN`  in  1  reset; asynchronous, active-low.
- `en`  in  1  capture enable.
- `clear`  in  1  synchronous flush of FIFO and status.
- `I`  in  1  probed net.
- `O`  in  1  probed net.
- `other`  in  1  probed net (XMR-bound bind wire).
- `out_valid`  out  1  head record available.
- `out_ready`  in  1  reader accepts head record.
- `out_data`  out  TS_WIDTH+3  {ts, other, O, I} of head record.
- `count`  out  clog2(DEPTH)+1  entries held.
- `overflow`  out  1  sticky: at least one record dropped.
- `drop_count`  out  8  dropped records, saturates at 255.

## Operation
- Reset values: `out_valid`=0, `out_data`=0, `count`=0, `overflow`=0, `drop_count`=0.
  - Internal state after reset: timestamp counter=0, previous-sample register=3'b000, `armed`=1.
- Timestamp counter `ts`: free-running. It increments every cycle regardless of `en`, wraps modulo 2^TS_WIDTH, and is never cleared by `clear`.
- Sample vector `s`={other,O,I}. Event at an edge when `en`=1 and (`armed`=1 or `s`≠prev).
  - The record is {ts, s}, where `ts` is the counter value before that edge.
- prev ← `s` on every edge where `en`=1; it holds while `en`=0.
- Arming: `armed` ← 1 on reset, on `clear`, and on any edge with `en`=0.
  - `armed` ← 0 on any edge with `en`=1.
  - Consequence: the first enabled cycle always records a baseline entry.
- Push: an event pushes when `count`<DEPTH, or when `count`=DEPTH and a pop occurs in the same cycle.
  - Otherwise the record is dropped: `overflow` ← 1 and `drop_count` increments, saturating at 255.
- Pop: occurs when `out_valid` & `out_ready`. Push and pop in the same cycle leave `count` unchanged.
- FIFO is first-word-fall-through. `out_data` shows the head entry. While `out_valid` & !`out_ready`, `out_data` and `out_valid` stay stable.
  - When empty, `out_data` holds its last value (0 after reset).
- `clear`=1 takes priority over push, pop and drop in that cycle. It empties the FIFO, zeroes `overflow` and `drop_count`, and sets `armed`.
  - `out_valid` is 0 the next cycle.
- Pointers are clog2(DEPTH) bits and wrap naturally. `count` is maintained separately and ranges 0..DEPTH.

## Timing
- Capture latency: an event at edge k makes the record visible with `out_valid`=1 in the cycle after edge k, if the FIFO was empty. No combinational path from probed inputs to outputs.
- `out_valid` depends only on registered state. `out_ready` does not combinationally affect `out_valid` or `out_data` in the same cycle.
- Throughput: one push and one pop per cycle sustained.
- Asserting `ASYNCRESETN`=0 mid-operation clears all state immediately, independent of `CLK`. In-flight records are lost. The first enabled edge after release records a baseline.
- Inputs are assumed synchronous to `CLK`. No synchronizers are included.

## Test plan
- Baseline and change:
  - Stimulus: reset, `en`=1 at edge 0 with `s`=000, `out_ready`=0. Toggle `I` at edge 3.
  - Required: records {0,000} and {3,001}; `count`=2; `out_valid`=1 from the cycle after edge 0.
- No-change suppression: hold `s` constant for 20 enabled cycles after the baseline → exactly 1 record, `count`=1.
- Full/overflow (DEPTH=8, `out_ready`=0):
  - Stimulus: toggle `other` every cycle for 12 cycles.
  - Required: `count`=8; `overflow`=1; `drop_count`=4 (12 events incl. baseline, 8 stored); the held records are the first 8 in order.
- Simultaneous push/pop at full:
  - Stimulus: with `count`=8, assert `out_ready`=1 while an event occurs.
  - Required: `count` stays 8; `drop_count` unchanged; new record appears at the tail.
- Clear vs. push:
  - Stimulus: assert `clear` in the same cycle as an event and a pop.
  - Required: next cycle `count`=0, `out_valid`=0, `overflow`=0, `drop_count`=0. The next enabled edge records a baseline.
- Async reset mid-stream: drop `ASYNCRESETN` between edges with `count`=5 → outputs 0 immediately; timestamp of the first post-reset record is 0.
